// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, issues single outstanding word reads to the I-cache
// and pushes fetched instructions with their predicted next PC into the queue.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic        prediction,
  input  logic        gshare_is_br,
  input  logic [31:0] branch_imm,
  input  logic        iq_full,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output logic        enq,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_next,
  output logic [31:0] out_inst,
  output logic        out_prediction
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_req_addr;
  logic [31:0] r_hold_inst;
  logic [31:0] r_hold_pc;
  logic        r_skip_resp;

  logic [31:0] w_pc_nxt;
  logic [31:0] w_tgt;
  logic [31:0] w_cur_pc;
  logic [31:0] w_cur_inst;
  logic [31:0] w_npc;
  logic        w_resp;
  logic        w_enq;

  // A response arriving in the first cycle after reset belongs to a pre-reset read.
  assign w_resp     = imem_resp && !r_skip_resp;
  assign w_tgt      = branch_target & ~32'd3;
  assign w_cur_pc   = (r_state == S_HOLD) ? r_hold_pc   : r_req_addr;
  assign w_cur_inst = (r_state == S_HOLD) ? r_hold_inst : imem_rdata;
  assign w_npc      = (gshare_is_br && prediction) ? branch_imm : w_cur_pc + 32'd4;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_enq       = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (branch) begin
          w_pc_nxt = w_tgt;
          if (!w_resp) w_state_nxt = S_DRAIN;
        end else if (w_resp) begin
          if (iq_full) begin
            w_state_nxt = S_HOLD;
          end else begin
            w_enq    = 1'b1;
            w_pc_nxt = w_npc;
          end
        end
      end
      S_HOLD: begin
        if (branch) begin
          w_pc_nxt    = w_tgt;
          w_state_nxt = S_FETCH;
        end else if (!iq_full) begin
          w_enq       = 1'b1;
          w_pc_nxt    = w_npc;
          w_state_nxt = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (branch) w_pc_nxt = w_tgt;
        if (w_resp) w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_FETCH;
    endcase
    if (rst) w_enq = 1'b0;
  end

  // req_addr tracks pc whenever the next state issues a read; DRAIN keeps the old address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_PC;
      r_req_addr  <= RESET_PC;
      r_hold_inst <= '0;
      r_hold_pc   <= '0;
      r_skip_resp <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_skip_resp <= 1'b0;
      if (w_state_nxt == S_FETCH) r_req_addr <= w_pc_nxt;
      if (r_state == S_FETCH && w_state_nxt == S_HOLD) begin
        r_hold_inst <= imem_rdata;
        r_hold_pc   <= r_req_addr;
      end
    end
  end

  assign imem_addr      = r_req_addr;
  assign imem_rmask     = (!rst && r_state != S_HOLD) ? '1 : '0;
  assign enq            = w_enq;
  assign out_pc         = w_enq ? w_cur_pc   : '0;
  assign out_inst       = w_enq ? w_cur_inst : '0;
  assign out_pc_next    = w_enq ? w_npc      : '0;
  assign out_prediction = w_enq ? prediction : 1'b0;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: cache and gshare environment models plus a transaction-level
// reference of which instruction must be enqueued or requested next.
module tb_fetch_stage;
  localparam logic [31:0] RPC = 32'h1eceb000;

  logic        clk = 1'b0;
  logic        rst, branch, prediction, gshare_is_br, iq_full, imem_resp;
  logic        enq, out_prediction;
  logic [31:0] branch_target, branch_imm, imem_addr, imem_rdata;
  logic [31:0] out_pc, out_pc_next, out_inst;
  logic [3:0]  imem_rmask;

  int errors = 0;
  int checks = 0;
  int unsigned gmode = 0;

  bit          c_busy = 0;
  logic [31:0] c_addr = '0;
  int          c_rem = 0;
  int          lat = 1;

  logic [31:0] exp_pc = RPC;
  bit          m_held = 0;
  bit          m_stale = 0;

  int          enq_cnt = 0;
  logic [31:0] last_pc, last_inst, last_pnext;
  logic        last_pred;
  logic [31:0] req_log[$];
  int          req_cyc[$];
  int          cyc = 0;

  fetch_stage #(.RESET_PC(32'h1eceb000)) dut (
    .clk(clk), .rst(rst), .branch(branch), .branch_target(branch_target),
    .prediction(prediction), .gshare_is_br(gshare_is_br), .branch_imm(branch_imm),
    .iq_full(iq_full), .imem_addr(imem_addr), .imem_rmask(imem_rmask),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp), .enq(enq), .out_pc(out_pc),
    .out_pc_next(out_pc_next), .out_inst(out_inst), .out_prediction(out_prediction)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // {is_br, taken, target} the predictor reports for the instruction at pc
  function automatic logic [33:0] gs_ref(input logic [31:0] pc, input int unsigned mode);
    logic [31:0] h;
    h = mem_word(pc);
    if (mode == 1) return {pc == 32'h1eceb004, pc == 32'h1eceb004, 32'h1eceb040};
    if (mode == 2) return {h[3], h[5], pc + {22'b0, h[13:6], 2'b00} + 32'd4};
    return {2'b00, 32'hFFFF_FFF0};
  endfunction

  always_comb {gshare_is_br, prediction, branch_imm} = gs_ref(out_pc, gmode);

  task automatic cycle(input logic br, input logic [31:0] tgt, input logic full,
                       input logic rs, input logic stray);
    logic        resp_now, exp_enq;
    logic [33:0] g;
    logic [31:0] npc;
    rst = rs; branch = br; branch_target = tgt; iq_full = full;
    imem_resp = 1'b0; imem_rdata = '0;
    #1;
    resp_now = 1'b0;
    if (rs) begin
      c_busy = 0;
    end else if (c_busy) begin
      checks++;
      if (imem_addr !== c_addr) begin
        errors++; $display("FAIL addr_stable: imem_addr=%h want %h", imem_addr, c_addr);
      end
      c_rem--;
      resp_now = (c_rem == 0);
    end else if (imem_rmask == 4'hF) begin
      checks++;
      if (imem_addr !== exp_pc) begin
        errors++; $display("FAIL req_addr: imem_addr=%h want %h", imem_addr, exp_pc);
      end
      c_busy = 1; c_addr = imem_addr; c_rem = lat;
      req_log.push_back(imem_addr); req_cyc.push_back(cyc);
    end
    imem_resp  = resp_now | stray;
    imem_rdata = resp_now ? mem_word(c_addr) : 32'hDEADBEEF;
    #1;
    exp_enq = !rs && !br && !full && (m_held || (resp_now && !m_stale));
    checks++;
    if (imem_rmask !== ((rs || m_held) ? 4'h0 : 4'hF)) begin
      errors++; $display("FAIL rmask: got %h want %h", imem_rmask, (rs || m_held) ? 4'h0 : 4'hF);
    end
    checks++;
    if (enq !== exp_enq) begin
      errors++; $display("FAIL enq: got %b want %b (cycle %0d)", enq, exp_enq, cyc);
    end
    g   = gs_ref(exp_pc, gmode);
    npc = (g[33] && g[32]) ? g[31:0] : exp_pc + 32'd4;
    checks++;
    if (exp_enq) begin
      if (out_pc !== exp_pc || out_inst !== mem_word(exp_pc) || out_pc_next !== npc ||
          out_prediction !== g[32]) begin
        errors++;
        $display("FAIL enq_fields: pc=%h inst=%h next=%h pred=%b want %h %h %h %b",
                 out_pc, out_inst, out_pc_next, out_prediction, exp_pc, mem_word(exp_pc), npc, g[32]);
      end
    end else if ({out_pc, out_inst, out_pc_next, out_prediction} !== '0) begin
      errors++;
      $display("FAIL idle_outputs: pc=%h inst=%h next=%h pred=%b want all zero",
               out_pc, out_inst, out_pc_next, out_prediction);
    end
    if (enq === 1'b1) begin
      enq_cnt++; last_pc = out_pc; last_inst = out_inst;
      last_pnext = out_pc_next; last_pred = out_prediction;
    end
    if (rs) begin
      exp_pc = RPC; m_held = 0; m_stale = 0;
    end else if (br) begin
      exp_pc = tgt & ~32'd3; m_held = 0;
      m_stale = c_busy && !resp_now;
    end else begin
      if (exp_enq) begin
        exp_pc = npc; m_held = 0;
      end else if (resp_now && !m_stale && full) begin
        m_held = 1;
      end
      if (resp_now) m_stale = 0;
    end
    if (resp_now) c_busy = 0;
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    req_log.delete(); req_cyc.delete(); enq_cnt = 0; cyc = 0;
  endtask

  task automatic wait_req(input int n);
    int k = 0;
    while (req_log.size() < n && k < 100) begin step(); k++; end
    checks++;
    if (req_log.size() < n) begin
      errors++; $display("FAIL wait_req: requests=%0d want %0d", req_log.size(), n);
    end
  endtask

  task automatic wait_due(input logic use_addr, input logic [31:0] a);
    int k = 0;
    while (!(c_busy && c_rem == 1 && (!use_addr || c_addr == a)) && k < 100) begin step(); k++; end
    checks++;
    if (!(c_busy && c_rem == 1)) begin
      errors++; $display("FAIL wait_due: no response due (addr %h) want one", c_addr);
    end
  endtask

  task automatic test_reset();
    gmode = 0; lat = 1;
    do_reset(3);
    step();
    checks++;
    if (req_log.size() != 1 || req_log[0] !== RPC || req_cyc[0] != 0) begin
      errors++; $display("FAIL first_req: n=%0d addr=%h want 1 %h at cycle 0",
                         req_log.size(), req_log.size() ? req_log[0] : '0, RPC);
    end
  endtask

  task automatic test_sequential();
    int k = 0;
    gmode = 0; lat = 1;
    do_reset(2);
    while (enq_cnt < 3 && k < 50) begin step(); k++; end
    wait_req(3);
    checks++;
    if (req_log[0] !== RPC || req_log[1] !== 32'h1eceb004 || req_log[2] !== 32'h1eceb008) begin
      errors++; $display("FAIL seq_addrs: %h %h %h want 1eceb000 1eceb004 1eceb008",
                         req_log[0], req_log[1], req_log[2]);
    end
    checks++;
    if (req_cyc[1] - req_cyc[0] != 2 || req_cyc[2] - req_cyc[1] != 2) begin
      errors++; $display("FAIL throughput: gaps %0d %0d want 2 2",
                         req_cyc[1] - req_cyc[0], req_cyc[2] - req_cyc[1]);
    end
    checks++;
    if (enq_cnt != 3 || last_pc !== 32'h1eceb008 || last_pnext !== 32'h1eceb00c || last_pred !== 1'b0) begin
      errors++; $display("FAIL seq_enq: n=%0d pc=%h next=%h pred=%b want 3 1eceb008 1eceb00c 0",
                         enq_cnt, last_pc, last_pnext, last_pred);
    end
  endtask

  task automatic test_predicted_branch();
    int k = 0;
    gmode = 1; lat = 1;
    do_reset(2);
    while (enq_cnt < 2 && k < 50) begin step(); k++; end
    checks++;
    if (enq_cnt != 2 || last_pc !== 32'h1eceb004 || last_pnext !== 32'h1eceb040 || last_pred !== 1'b1) begin
      errors++; $display("FAIL beq_enq: n=%0d pc=%h next=%h pred=%b want 2 1eceb004 1eceb040 1",
                         enq_cnt, last_pc, last_pnext, last_pred);
    end
    wait_req(3);
    checks++;
    if (req_log[2] !== 32'h1eceb040) begin
      errors++; $display("FAIL beq_target_req: %h want 1eceb040", req_log[2]);
    end
    gmode = 0;
  endtask

  task automatic test_iq_full();
    gmode = 0; lat = 1;
    do_reset(2);
    wait_due(1'b1, 32'h1eceb008);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (enq_cnt != 2) begin
      errors++; $display("FAIL hold_no_enq: enq count %0d want 2", enq_cnt);
    end
    step();
    checks++;
    if (enq_cnt != 3 || last_pc !== 32'h1eceb008 || last_inst !== mem_word(32'h1eceb008)) begin
      errors++; $display("FAIL hold_release: n=%0d pc=%h inst=%h want 3 1eceb008 %h",
                         enq_cnt, last_pc, last_inst, mem_word(32'h1eceb008));
    end
    wait_req(4);
    checks++;
    if (req_log[3] !== 32'h1eceb00c) begin
      errors++; $display("FAIL hold_resume: %h want 1eceb00c", req_log[3]);
    end
  endtask

  task automatic test_branch_drain();
    gmode = 0; lat = 1;
    do_reset(2);
    wait_due(1'b1, 32'h1eceb008);
    step();
    lat = 4;
    step();
    cycle(1'b1, 32'h1eceb100, 1'b0, 1'b0, 1'b0);
    wait_req(5);
    checks++;
    if (req_log[3] !== 32'h1eceb00c || req_log[4] !== 32'h1eceb100 || enq_cnt != 3) begin
      errors++; $display("FAIL drain1: reqs %h %h enq %0d want 1eceb00c 1eceb100 3",
                         req_log[3], req_log[4], enq_cnt);
    end
    cycle(1'b1, 32'h1eceb180, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h1eceb200, 1'b0, 1'b0, 1'b0);
    wait_req(6);
    checks++;
    if (req_log[5] !== 32'h1eceb200 || enq_cnt != 3) begin
      errors++; $display("FAIL drain2: req %h enq %0d want 1eceb200 3", req_log[5], enq_cnt);
    end
  endtask

  task automatic test_branch_resp_hold();
    int e0;
    int k = 0;
    gmode = 0; lat = 2;
    do_reset(2);
    wait_due(1'b0, '0);
    e0 = enq_cnt;
    cycle(1'b1, 32'h1eceb300, 1'b0, 1'b0, 1'b0);
    wait_req(2);
    checks++;
    if (enq_cnt != e0 || req_log[1] !== 32'h1eceb300) begin
      errors++; $display("FAIL br_with_resp: enq %0d req %h want %0d 1eceb300", enq_cnt, req_log[1], e0);
    end
    wait_due(1'b0, '0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h1eceb403, 1'b1, 1'b0, 1'b0);
    wait_req(3);
    checks++;
    if (enq_cnt != e0 || req_log[2] !== 32'h1eceb400) begin
      errors++; $display("FAIL br_in_hold: enq %0d req %h want %0d 1eceb400", enq_cnt, req_log[2], e0);
    end
    while (enq_cnt == e0 && k < 20) begin step(); k++; end
    checks++;
    if (last_pc !== 32'h1eceb400) begin
      errors++; $display("FAIL after_hold_flush: pc %h want 1eceb400", last_pc);
    end
  endtask

  task automatic test_reset_drain();
    int k = 0;
    gmode = 0; lat = 4;
    do_reset(2);
    wait_req(1);
    cycle(1'b1, 32'h1eceb500, 1'b0, 1'b0, 1'b0);
    step();
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
    req_log.delete(); req_cyc.delete(); enq_cnt = 0; cyc = 0;
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (req_log.size() != 1 || req_log[0] !== RPC) begin
      errors++; $display("FAIL reset_restart: n=%0d addr=%h want 1 %h",
                         req_log.size(), imem_addr, RPC);
    end
    while (enq_cnt < 1 && k < 20) begin step(); k++; end
    checks++;
    if (last_pc !== RPC || last_inst !== mem_word(RPC)) begin
      errors++; $display("FAIL reset_first_enq: pc=%h inst=%h want %h %h",
                         last_pc, last_inst, RPC, mem_word(RPC));
    end
  endtask

  task automatic test_random();
    gmode = 2; lat = 1;
    do_reset(2);
    for (int i = 0; i < 1000; i++) begin
      lat = $urandom_range(1, 4);
      cycle($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 3) == 0, 1'b0, 1'b0);
    end
    checks++;
    if (enq_cnt < 50) begin
      errors++; $display("FAIL random_progress: enq count %0d want >= 50", enq_cnt);
    end
  endtask

  initial begin
    rst = 1'b1; branch = 1'b0; branch_target = '0; iq_full = 1'b0;
    imem_resp = 1'b0; imem_rdata = '0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_predicted_branch();
    test_iq_full();
    test_branch_drain();
    test_branch_resp_hold();
    test_reset_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
